// File: rtl/pipeline_stall_controller_if.sv
// Pipeline hazard/stall bus between the pipeline datapath and the stall
// controller.
//   master : pipeline side; drives hazard sources and counter clear,
//            receives stage write enables, bubble/flush and counters.
//   slave  : controller side; mirror of master.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             mem_read_ID_EXE;
  logic [4:0]       Rd_ID_EXE;
  logic [4:0]       Rs1_IF_ID;
  logic [4:0]       Rs2_IF_ID;
  logic             branch_taken_EXE;
  logic             dmem_req;
  logic             dmem_ready;
  logic             clr_counters;

  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXWrite;
  logic             EXMEMWrite;
  logic             MEMWBWrite;
  logic             bubble_ID_EXE;
  logic             flush_IF_ID;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output enable, mem_read_ID_EXE, Rd_ID_EXE, Rs1_IF_ID, Rs2_IF_ID,
           branch_taken_EXE, dmem_req, dmem_ready, clr_counters,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
           bubble_ID_EXE, flush_IF_ID, stall_count, flush_count
  );

  modport slave (
    input  enable, mem_read_ID_EXE, Rd_ID_EXE, Rs1_IF_ID, Rs2_IF_ID,
           branch_taken_EXE, dmem_req, dmem_ready, clr_counters,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
           bubble_ID_EXE, flush_IF_ID, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. Combines load-use hazards,
// taken-branch redirects and data-memory waits into per-stage write enables
// plus bubble/flush controls, and keeps saturating stall/flush counters.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : pipeline_stall_controller_if.slave (hazard sources in,
//          stage controls and counters out)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_HALT     | pipeline frozen, waiting for enable
// ST_RUN      | normal operation; mem wait > branch flush > load-use stall
// ST_MEM_WAIT | frozen until dmem_ready, then RUN or HALT per enable
module pipeline_stall_controller #(
  parameter int CNT_W = 16
) (
  input logic                       clk,
  input logic                       rst,
  pipeline_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic hz, mw;
  logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic bubble, flush, flush_inc, stall_inc;

  // Rd = x0 never creates a dependency.
  assign hz = bus.mem_read_ID_EXE && (bus.Rd_ID_EXE != 5'd0) &&
              ((bus.Rd_ID_EXE == bus.Rs1_IF_ID) || (bus.Rd_ID_EXE == bus.Rs2_IF_ID));
  assign mw = bus.dmem_req && !bus.dmem_ready;

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    memwb_write = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    flush_inc   = 1'b0;

    case (state_q)
      ST_HALT: begin
        state_d = bus.enable ? ST_RUN : ST_HALT;
      end
      ST_RUN: begin
        if (mw) begin
          // Freeze now; enable is honoured only once the access completes.
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = bus.enable ? ST_RUN : ST_HALT;
          if (bus.branch_taken_EXE) begin
            // ID instruction is squashed, so a concurrent hazard is moot.
            {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b11111;
            bubble    = 1'b1;
            flush     = 1'b1;
            flush_inc = 1'b1;
          end else if (hz) begin
            {idex_write, exmem_write, memwb_write} = 3'b111;
            bubble = 1'b1;
          end else begin
            {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b11111;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = bus.enable ? ST_RUN : ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign stall_inc = !pc_write && (state_q != ST_HALT);

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (bus.clr_counters) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_inc && (stall_count_q != CNT_MAX)) stall_count_d = stall_count_q + CNT_ONE;
      if (flush_inc && (flush_count_q != CNT_MAX)) flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HALT;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.PCWrite       = pc_write;
  assign bus.IFIDWrite     = ifid_write;
  assign bus.IDEXWrite     = idex_write;
  assign bus.EXMEMWrite    = exmem_write;
  assign bus.MEMWBWrite    = memwb_write;
  assign bus.bubble_ID_EXE = bubble;
  assign bus.flush_IF_ID   = flush;
  assign bus.stall_count   = stall_count_q;
  assign bus.flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller built with 4-bit counters.
// Each step drives one cycle of inputs, queues the expected decode
// {PC,IFID,IDEX,EXMEM,MEMWB,bubble,flush} and counter values, then pops and
// compares them at the falling edge.
module tb_pipeline_stall_controller;

  localparam int CNT_W = 4;

  localparam logic [6:0] O_FRZ = 7'b00000_00;
  localparam logic [6:0] O_ALL = 7'b11111_00;
  localparam logic [6:0] O_HZ  = 7'b00111_10;
  localparam logic [6:0] O_BR  = 7'b11111_11;

  typedef struct {
    logic [6:0] out;
    logic [3:0] st;
    logic [3:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_controller #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic en, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic br, input logic req, input logic rdy,
                      input logic clr, input logic r,
                      input logic [6:0] e_out, input logic [3:0] e_st,
                      input logic [3:0] e_fl, input string tag);
    exp_t e, got;
    logic [6:0] obs;
    bus.enable           = en;
    bus.mem_read_ID_EXE  = mr;
    bus.Rd_ID_EXE        = rd;
    bus.Rs1_IF_ID        = rs1;
    bus.Rs2_IF_ID        = rs2;
    bus.branch_taken_EXE = br;
    bus.dmem_req         = req;
    bus.dmem_ready       = rdy;
    bus.clr_counters     = clr;
    rst                  = r;
    e.out = e_out;
    e.st  = e_st;
    e.fl  = e_fl;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    obs = {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite,
           bus.MEMWBWrite, bus.bubble_ID_EXE, bus.flush_IF_ID};
    checks++;
    assert (obs === got.out) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, got.out);
    end
    checks++;
    assert (bus.stall_count === got.st) else begin
      failures++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", tag, bus.stall_count, got.st);
    end
    checks++;
    assert (bus.flush_count === got.fl) else begin
      failures++;
      $error("FAIL %s flush_count observed=%0d expected=%0d", tag, bus.flush_count, got.fl);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.enable = 0; bus.mem_read_ID_EXE = 0; bus.Rd_ID_EXE = 0;
    bus.Rs1_IF_ID = 0; bus.Rs2_IF_ID = 0; bus.branch_taken_EXE = 0;
    bus.dmem_req = 0; bus.dmem_ready = 0; bus.clr_counters = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    //    en mr rd  rs1 rs2 br rq ry cl rst  out    st  fl
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_FRZ, 0, 0, "halt_after_rst");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 0, 0, "run_clean");
    step(1, 1, 5,  5,  0,  0, 0, 0, 0, 0, O_HZ,  0, 0, "hz_rs1");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 1, 0, "after_hz");
    step(1, 1, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 1, 0, "hz_x0");
    step(1, 1, 7,  3,  7,  0, 0, 0, 0, 0, O_HZ,  1, 0, "hz_rs2");
    step(1, 0, 0,  0,  0,  0, 0, 0, 1, 0, O_ALL, 2, 0, "clr");
    step(1, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FRZ, 0, 0, "mw_run");
    step(1, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FRZ, 1, 0, "mw_wait1");
    step(1, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FRZ, 2, 0, "mw_wait2");
    step(1, 0, 0,  0,  0,  0, 1, 1, 0, 0, O_FRZ, 3, 0, "mw_ready");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 4, 0, "mw_resume");
    step(1, 1, 5,  5,  0,  1, 0, 0, 0, 0, O_BR,  4, 0, "br_and_hz");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 4, 1, "after_br");
    step(1, 0, 0,  0,  0,  1, 1, 0, 0, 0, O_FRZ, 4, 1, "br_and_mw");
    step(1, 0, 0,  0,  0,  1, 1, 0, 0, 0, O_FRZ, 5, 1, "br_in_wait");
    step(1, 0, 0,  0,  0,  1, 1, 1, 0, 0, O_FRZ, 6, 1, "br_wait_ready");
    step(1, 0, 0,  0,  0,  1, 0, 0, 0, 0, O_BR,  7, 1, "br_after_wait");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 7, 2, "after_br2");
    step(1, 0, 0,  0,  0,  0, 1, 1, 0, 0, O_ALL, 7, 2, "zero_wait");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 7, 2, "after_zero_wait");
    step(1, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FRZ, 7, 2, "mw_en_drop");
    step(0, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FRZ, 8, 2, "wait_en0");
    step(0, 0, 0,  0,  0,  0, 1, 1, 0, 0, O_FRZ, 9, 2, "wait_en0_ready");
    step(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_FRZ, 10, 2, "halt_no_count");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_FRZ, 10, 2, "halt_enable");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 10, 2, "run_again");
    step(0, 1, 5,  5,  0,  0, 0, 0, 0, 0, O_HZ,  10, 2, "drain_hz");
    step(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_FRZ, 11, 2, "halt_after_drain");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_FRZ, 11, 2, "halt_enable2");
    step(1, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FRZ, 11, 2, "mw_before_rst");
    step(1, 0, 0,  0,  0,  0, 1, 0, 0, 1, O_FRZ, 12, 2, "rst_in_wait");
    step(0, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FRZ, 0, 0, "halt_after_rst2");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_FRZ, 0, 0, "halt_enable3");
    step(1, 0, 0,  0,  0,  0, 1, 0, 0, 0, O_FRZ, 0, 0, "sat_start");
    for (int i = 1; i <= 17; i++) begin
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_FRZ,
           (i > 15) ? 4'd15 : 4'(i), 0, "sat_wait");
    end
    step(1, 0, 0,  0,  0,  0, 1, 0, 1, 0, O_FRZ, 15, 0, "clr_with_stall");
    step(1, 0, 0,  0,  0,  0, 1, 1, 0, 0, O_FRZ, 0, 0, "after_clr");
    step(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_ALL, 1, 0, "final_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
